decode_rr_sched: RTL and testbench
==================================

Name: decode_rr_sched

Overview:
Round-robin scheduler that shares one registered cond-to-code decode unit between NREQ requesters. The decode maps (cond & 4'b1110) through the fixed table 0h->7, 2h->6, 4h->5, 6h->4, 8h->3, Ah->2, Ch->1, Eh->0 to get t, then returns q = ~t (3 bits). The block sits between requester agents and the decode datapath and sequences one lookup at a time through a 3-state FSM.

Parameters:
NREQ, 4, number of requesters (2..8).
IW, $clog2(NREQ), width of grant index (derived; not overridden).

Ports:
clk  input  1  clock; all state updates on posedge clk.
rst  input  1  reset; synchronous, active-high.
req  input  NREQ  per-requester request level; bit i = requester i.
cond_flat  input  4*NREQ  packed cond values; cond of requester i = cond_flat[4*i+3:4*i].
ack  output  NREQ  one-hot, one-cycle pulse: requester i's lookup done.
result  output  3  decoded q for the acked requester; valid only while result_valid=1.
result_valid  output  1  high exactly when any ack bit is high.
grant_idx  output  IW  index of requester currently owning the decoder.
busy  output  1  high in LOOKUP and RESP.

Behaviour:
- Reset is synchronous and active-high, and overrides everything at the edge. After any edge with rst=1: state=IDLE, ack=0, result=0, result_valid=0, grant_idx=0, busy=0, rr pointer=0. A reset during LOOKUP or RESP aborts the lookup with no ack.
- FSM states: IDLE, LOOKUP, RESP. All outputs are registered or decoded from registered state only; there is no combinational path from req to ack.
- IDLE: if |req at the edge, pick the first set bit scanning ptr, ptr+1, ... modulo NREQ. Latch grant_idx and that requester's cond, then go to LOOKUP. If req=0, stay in IDLE.
- LOOKUP: t = table(cond_latched & 4'b1110). Equivalently t = 7 - cond_latched[3:1]. Register result = ~t, which equals cond_latched[3:1]. Register ack = one-hot(grant_idx) and result_valid=1. Go to RESP.
- RESP: ack, result and result_valid are visible for this one cycle. At the edge, clear ack and result_valid, set ptr = (grant_idx+1) mod NREQ, and go to IDLE. result holds its value after RESP; only result_valid qualifies it.
- Latency: req sampled at edge k; ack is high between edges k+2 and k+3 (k+1 -> LOOKUP, k+2 -> RESP). Throughput is at most one lookup per 3 cycles.
- cond bit 0 is ignored (mask 4'b1110). cond is latched at grant; later changes to cond have no effect on the lookup in flight.
- Dropping req after the grant does not cancel the lookup; the ack is still issued.
- req still high at the first IDLE edge after RESP counts as a new request, arbitrated fairly with ptr already advanced.
- ptr wraps from NREQ-1 to 0.
- Simultaneous requests: exactly one grant per pass, chosen by ptr priority. No starvation; worst-case wait is NREQ*3 cycles.
- X/Z on req bits is out of scope; the bench drives only 0/1.

Decomposition:
- Package decode_rr_pkg:
  - state enum {IDLE, LOOKUP, RESP}
  - constant COND_MASK = 4'b1110
  - function decode_t(cond) implementing the 8-entry table, returning 3-bit t
- One combinational sub-module, decode_rr_pick:
  - inputs: req[NREQ], ptr[IW]
  - outputs: any, idx[IW]
  - rotate / priority-scan only; no state.
- The FSM, latches and output registers live in decode_rr_sched.

Test Plan:
1. Hold rst=1 for 2 edges with req=4'hF -> ack=0, result=0, result_valid=0, busy=0, grant_idx=0; first grant after release goes to req0.
2. req=4'b0001 with cond0=4'hC, sampled at edge k -> busy=1 from k+1; ack=4'b0001 and result=3'b110 only between k+2 and k+3; IDLE after k+3.
3. cond0=4'hD, then cond0=4'h1 -> results 3'b110, then 3'b000 (bit 0 ignored); cond0=4'hE -> 3'b111.
4. req=4'hF with conds 0h,2h,4h,6h held high throughout -> acks in order 0,1,2,3 and repeating, spaced 3 cycles apart, with results 0,1,2,3.
5. req0 and req2 both held high (NREQ=4) -> grant sequence 0,2,0,2; req1 and req3 never acked.
6. req1 granted, rst=1 at the edge where state=LOOKUP -> no ack pulse; with req=4'b0011 afterwards, the next ack is ack[0] (ptr reset to 0).

Source files
------------

// File: rtl/decode_rr_sched_pkg.sv
// Shared types, constants and the cond-to-code decode table for the
// round-robin decode scheduler.
package decode_rr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] COND_MASK = 4'b1110;

    // Fixed 8-entry table; cond bit 0 is masked off before lookup.
    function automatic logic [2:0] decode_t(input logic [3:0] cond);
        logic [2:0] t;
        case (cond & COND_MASK)
            4'h0:    t = 3'd7;
            4'h2:    t = 3'd6;
            4'h4:    t = 3'd5;
            4'h6:    t = 3'd4;
            4'h8:    t = 3'd3;
            4'hA:    t = 3'd2;
            4'hC:    t = 3'd1;
            4'hE:    t = 3'd0;
            default: t = 3'd0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/decode_rr_sched_if.sv
// Requester-side bus of the decode scheduler: request levels, packed
// cond values, and the registered ack/result/status returned to agents.
interface decode_rr_sched_if #(
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] cond_flat;
    logic [NREQ-1:0]   ack;
    logic [2:0]        result;
    logic              result_valid;
    logic [IW-1:0]     grant_idx;
    logic              busy;

    modport master (
        output req, cond_flat,
        input  ack, result, result_valid, grant_idx, busy
    );

    modport slave (
        input  req, cond_flat,
        output ack, result, result_valid, grant_idx, busy
    );

endinterface

// File: rtl/decode_rr_sched_pick.sv
// Rotating priority picker: finds the first set request bit scanning
// ptr, ptr+1, ... modulo NREQ. Purely combinational.
module decode_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_any,
    output logic [IW-1:0]   o_idx
);

    // Scan from the farthest offset down so the nearest-to-ptr hit wins.
    always_comb begin
        int p;
        o_any = 1'b0;
        o_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            p = int'(i_ptr) + k;
            if (p >= NREQ) p = p - NREQ;
            if (i_req[p]) begin
                o_any = 1'b1;
                o_idx = IW'(p);
            end
        end
    end

endmodule

// File: rtl/decode_rr_sched.sv
// Round-robin scheduler sharing one registered decode unit among NREQ
// requesters; one lookup at a time through IDLE -> LOOKUP -> RESP.
module decode_rr_sched
    import decode_rr_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    decode_rr_sched_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_grant;
    logic [3:0]        r_cond;
    logic [NREQ-1:0]   r_ack;
    logic [2:0]        r_result;
    logic              r_valid;
    logic              w_any;
    logic [IW-1:0]     w_idx;
    logic [3:0]        w_cond;

    decode_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    // Select the cond nibble of the requester the picker chose.
    always_comb begin
        w_cond = 4'h0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == IW'(i)) w_cond = bus.cond_flat[4*i +: 4];
        end
    end

    // Next-state logic; RESP always returns to IDLE so a held req re-arbitrates.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = LOOKUP;
            LOOKUP:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, grant latches and registered outputs; reset aborts any lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_cond   <= 4'h0;
            r_ack    <= '0;
            r_result <= 3'd0;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_idx;
                        r_cond  <= w_cond;
                    end
                end
                LOOKUP: begin
                    r_result <= ~decode_t(r_cond);
                    r_ack    <= NREQ'(1) << r_grant;
                    r_valid  <= 1'b1;
                end
                RESP: begin
                    r_ack   <= '0;
                    r_valid <= 1'b0;
                    r_ptr   <= (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ack          = r_ack;
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign bus.grant_idx    = r_grant;
    assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_decode_rr_sched.sv
// Directed self-checking bench for decode_rr_sched with NREQ=4.
module tb_decode_rr_sched;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    decode_rr_sched_if #(.NREQ(4)) bus ();

    decode_rr_sched #(.NREQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'hF;
        bus.cond_flat = 16'h0000;
        step();
        step();
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
        n_tests++; if (bus.result !== 3'b000) begin n_fail++; $display("FAIL reset_result: got %b expected 000", bus.result); end
        n_tests++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.result_valid); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_tests++; if (bus.grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", bus.grant_idx); end
        rst = 1'b0;
        step();
        n_tests++; if (bus.busy !== 1'b1 || bus.grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_first_grant: busy %b grant %0d expected busy 1 grant 0", bus.busy, bus.grant_idx); end
        bus.req = 4'h0;
        step();
        n_tests++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ack: got %b expected 0001", bus.ack); end
        step();
    endtask

    task automatic test_single();
        bus.cond_flat = 16'h000C;
        bus.req = 4'b0001;
        step();
        n_tests++; if (bus.busy !== 1'b1 || bus.ack !== 4'b0000 || bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL single_lookup: busy %b ack %b valid %b expected 1 0000 0", bus.busy, bus.ack, bus.result_valid); end
        bus.req = 4'b0000;
        bus.cond_flat = 16'h0000;
        step();
        n_tests++; if (bus.ack !== 4'b0001 || bus.result !== 3'b110 || bus.result_valid !== 1'b1) begin n_fail++; $display("FAIL single_resp: ack %b result %b valid %b expected 0001 110 1", bus.ack, bus.result, bus.result_valid); end
        n_tests++; if (bus.busy !== 1'b1 || bus.grant_idx !== 2'd0) begin n_fail++; $display("FAIL single_resp_busy: busy %b grant %0d expected 1 0", bus.busy, bus.grant_idx); end
        step();
        n_tests++; if (bus.ack !== 4'b0000 || bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: ack %b valid %b busy %b expected 0000 0 0", bus.ack, bus.result_valid, bus.busy); end
        n_tests++; if (bus.result !== 3'b110) begin n_fail++; $display("FAIL single_result_hold: got %b expected 110", bus.result); end
        step();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_stay_idle: busy %b expected 0", bus.busy); end
    endtask

    task automatic test_cond_mask();
        logic [3:0] conds [5] = '{4'hD, 4'h1, 4'hE, 4'h7, 4'h8};
        logic [2:0] exps  [5] = '{3'b110, 3'b000, 3'b111, 3'b011, 3'b100};
        for (int i = 0; i < 5; i++) begin
            bus.cond_flat = {12'h000, conds[i]};
            bus.req = 4'b0001;
            step();
            bus.req = 4'b0000;
            step();
            n_tests++; if (bus.ack !== 4'b0001 || bus.result !== exps[i]) begin n_fail++; $display("FAIL cond_mask[%0d] cond %h: ack %b result %b expected 0001 %b", i, conds[i], bus.ack, bus.result, exps[i]); end
            step();
        end
    endtask

    task automatic test_all_req();
        do_reset();
        bus.cond_flat = 16'h6420;
        bus.req = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++; if (bus.ack !== 4'b0000 || bus.grant_idx !== 2'(i % 4)) begin n_fail++; $display("FAIL all_req_lookup[%0d]: ack %b grant %0d expected 0000 %0d", i, bus.ack, bus.grant_idx, i % 4); end
            step();
            n_tests++; if (bus.ack !== (4'b0001 << (i % 4)) || bus.result !== 3'(i % 4)) begin n_fail++; $display("FAIL all_req_resp[%0d]: ack %b result %0d expected %b %0d", i, bus.ack, bus.result, 4'b0001 << (i % 4), i % 4); end
            step();
        end
        bus.req = 4'h0;
        step();
    endtask

    task automatic test_two_req();
        logic [3:0] exp_ack [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        do_reset();
        bus.cond_flat = 16'hA8CE;
        bus.req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            step();
            step();
            n_tests++; if (bus.ack !== exp_ack[i]) begin n_fail++; $display("FAIL two_req[%0d]: ack %b expected %b", i, bus.ack, exp_ack[i]); end
            step();
        end
        bus.req = 4'h0;
        step();
    endtask

    task automatic test_reset_abort();
        do_reset();
        bus.cond_flat = 16'h0000;
        bus.req = 4'b0010;
        step();
        n_tests++; if (bus.busy !== 1'b1 || bus.grant_idx !== 2'd1) begin n_fail++; $display("FAIL abort_grant: busy %b grant %0d expected 1 1", bus.busy, bus.grant_idx); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.grant_idx !== 2'd0) begin n_fail++; $display("FAIL abort_no_ack: ack %b busy %b grant %0d expected 0000 0 0", bus.ack, bus.busy, bus.grant_idx); end
        bus.req = 4'b0011;
        step();
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL abort_gap: ack %b expected 0000", bus.ack); end
        step();
        n_tests++; if (bus.ack !== 4'b0001) begin n_fail++; $display("FAIL abort_next_ack: ack %b expected 0001", bus.ack); end
        bus.req = 4'h0;
        step();
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.req = 4'h0;
        bus.cond_flat = 16'h0000;
        test_reset();
        test_single();
        test_cond_mask();
        test_all_req();
        test_two_req();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
